// File: rtl/srv_mem_pkg.sv
// Shared types and helpers for the two-port memory arbiter.
// Line/word geometry, arbiter states and request payloads.
package srv_mem_pkg;

   localparam int unsigned LINE_W         = 128;
   localparam int unsigned WORD_W         = 32;
   localparam int unsigned WORDS_PER_LINE = LINE_W / WORD_W;
   localparam int unsigned ADDR_W         = 32;
   localparam int unsigned BE_W           = WORD_W / 8;
   localparam int unsigned STRB_W         = LINE_W / 8;

   typedef enum logic [1:0] {
      IDLE,
      BUSY_I,
      BUSY_D
   } arb_state_t;

   // Request as presented on the memory port
   typedef struct packed {
      logic                we;
      logic [ADDR_W-1:0]   addr;
      logic [LINE_W-1:0]   wdata;
      logic [STRB_W-1:0]   wstrb;
   } mem_req_t;

   // Request as captured from a requester port
   typedef struct packed {
      logic                we;
      logic [ADDR_W-1:0]   addr;
      logic [WORD_W-1:0]   wdata;
      logic [BE_W-1:0]     be;
   } port_req_t;

   function automatic logic [WORD_W-1:0] word_sel(input logic [LINE_W-1:0] line,
                                                  input logic [1:0]        off);
      return line[{off, 5'd0} +: WORD_W];
   endfunction

   function automatic logic [STRB_W-1:0] strb_place(input logic [BE_W-1:0] be,
                                                    input logic [1:0]      off);
      return STRB_W'(be) << {off, 2'b00};
   endfunction

endpackage

// File: rtl/srv_mem_req_latch.sv
// Per-port request capture: pending flag plus latched request fields.
// New pulses are dropped while the port already has a request pending or in flight.
module srv_mem_req_latch
   import srv_mem_pkg::*;
(
   input  logic      clk,
   input  logic      rst,
   input  logic      req,
   input  port_req_t fields_in,
   input  logic      busy,
   input  logic      clear,
   output logic      pend,
   output port_req_t fields
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pend   <= 1'b0;
         fields <= '0;
      end else if (clear) begin
         pend <= 1'b0;
      end else if (req && !pend && !busy) begin
         pend   <= 1'b1;
         fields <= fields_in;
      end
   end

endmodule

// File: rtl/srv_mem_arbiter.sv
// Round-robin arbiter sharing one line-wide memory port between the I-refill
// and data ports, one transaction in flight, with a response timeout.
module srv_mem_arbiter
   import srv_mem_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 255,
   parameter int unsigned CNT_W          = 8
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                i_req_i,
   input  logic [ADDR_W-1:0]   i_addr_i,
   output logic                i_rsp_o,
   output logic [LINE_W-1:0]   i_rdata_o,
   output logic                i_err_o,
   input  logic                d_req_i,
   input  logic                d_we_i,
   input  logic [ADDR_W-1:0]   d_addr_i,
   input  logic [WORD_W-1:0]   d_wdata_i,
   input  logic [BE_W-1:0]     d_be_i,
   output logic                d_rsp_o,
   output logic [WORD_W-1:0]   d_rdata_o,
   output logic                d_err_o,
   output logic                mem_req_o,
   output logic                mem_we_o,
   output logic [ADDR_W-1:0]   mem_addr_o,
   output logic [LINE_W-1:0]   mem_wdata_o,
   output logic [STRB_W-1:0]   mem_wstrb_o,
   input  logic                mem_rsp_i,
   input  logic [LINE_W-1:0]   mem_rdata_i
);

   localparam logic             TO_EN  = (TIMEOUT_CYCLES != 0);
   localparam logic [CNT_W-1:0] TO_VAL = CNT_W'(TIMEOUT_CYCLES);

   arb_state_t       state;
   logic             last_d;
   logic [CNT_W-1:0] cnt;
   logic [1:0]       d_off;

   logic      pend_i, pend_d;
   port_req_t lat_i, lat_d;
   port_req_t in_i_c, in_d_c;
   mem_req_t  req_i_c, req_d_c;
   logic      grant_i_c, grant_d_c;
   logic      timeout_c, done_c, busy_i_c, busy_d_c;

   // Port payloads into the capture latches
   always_comb begin
      in_i_c       = '0;
      in_i_c.addr  = i_addr_i;
      in_d_c       = '0;
      in_d_c.we    = d_we_i;
      in_d_c.addr  = d_addr_i;
      in_d_c.wdata = d_wdata_i;
      in_d_c.be    = d_be_i;
   end

   // Completion frees the port in the same cycle so a new pulse is not lost
   always_comb begin
      timeout_c = TO_EN && (cnt == TO_VAL);
      done_c    = (state != IDLE) && (mem_rsp_i || timeout_c);
      busy_i_c  = (state == BUSY_I) && !done_c;
      busy_d_c  = (state == BUSY_D) && !done_c;
   end

   srv_mem_req_latch u_lat_i (
      .clk       (clk),
      .rst       (rst),
      .req       (i_req_i),
      .fields_in (in_i_c),
      .busy      (busy_i_c),
      .clear     (grant_i_c),
      .pend      (pend_i),
      .fields    (lat_i)
   );

   srv_mem_req_latch u_lat_d (
      .clk       (clk),
      .rst       (rst),
      .req       (d_req_i),
      .fields_in (in_d_c),
      .busy      (busy_d_c),
      .clear     (grant_d_c),
      .pend      (pend_d),
      .fields    (lat_d)
   );

   // Round-robin: on a tie the port that did not win last time goes first
   always_comb begin
      grant_i_c = (state == IDLE) && pend_i && (!pend_d || last_d);
      grant_d_c = (state == IDLE) && pend_d && !grant_i_c;
   end

   // Memory-side view of each latched request
   always_comb begin
      req_i_c       = '0;
      req_i_c.addr  = lat_i.addr;
      req_d_c.we    = lat_d.we;
      req_d_c.addr  = {lat_d.addr[ADDR_W-1:2], 2'b00};
      req_d_c.wdata = {WORDS_PER_LINE{lat_d.wdata}};
      req_d_c.wstrb = lat_d.we ? strb_place(lat_d.be, lat_d.addr[1:0]) : '0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         last_d      <= 1'b1;
         cnt         <= '0;
         d_off       <= '0;
         mem_req_o   <= 1'b0;
         mem_we_o    <= 1'b0;
         mem_addr_o  <= '0;
         mem_wdata_o <= '0;
         mem_wstrb_o <= '0;
         i_rsp_o     <= 1'b0;
         i_err_o     <= 1'b0;
         i_rdata_o   <= '0;
         d_rsp_o     <= 1'b0;
         d_err_o     <= 1'b0;
         d_rdata_o   <= '0;
      end else begin
         mem_req_o <= 1'b0;
         i_rsp_o   <= 1'b0;
         i_err_o   <= 1'b0;
         d_rsp_o   <= 1'b0;
         d_err_o   <= 1'b0;
         unique case (state)
            IDLE: begin
               if (grant_i_c) begin
                  state     <= BUSY_I;
                  last_d    <= 1'b0;
                  cnt       <= '0;
                  mem_req_o <= 1'b1;
                  {mem_we_o, mem_addr_o, mem_wdata_o, mem_wstrb_o} <= req_i_c;
               end else if (grant_d_c) begin
                  state     <= BUSY_D;
                  last_d    <= 1'b1;
                  cnt       <= '0;
                  d_off     <= lat_d.addr[1:0];
                  mem_req_o <= 1'b1;
                  {mem_we_o, mem_addr_o, mem_wdata_o, mem_wstrb_o} <= req_d_c;
               end
            end
            BUSY_I: begin
               if (mem_rsp_i) begin
                  state     <= IDLE;
                  i_rsp_o   <= 1'b1;
                  i_rdata_o <= mem_rdata_i;
               end else if (timeout_c) begin
                  state   <= IDLE;
                  i_rsp_o <= 1'b1;
                  i_err_o <= 1'b1;
               end else if (cnt != '1) begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            BUSY_D: begin
               if (mem_rsp_i) begin
                  state   <= IDLE;
                  d_rsp_o <= 1'b1;
                  if (!mem_we_o) d_rdata_o <= word_sel(mem_rdata_i, d_off);
               end else if (timeout_c) begin
                  state   <= IDLE;
                  d_rsp_o <= 1'b1;
                  d_err_o <= 1'b1;
               end else if (cnt != '1) begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_srv_mem_arbiter.sv
// Directed bench for srv_mem_arbiter: memory-request scoreboard plus
// response, round-robin, timeout and reset checks.
module tb_srv_mem_arbiter;
   import srv_mem_pkg::*;

   typedef struct {
      bit       is_d;
      mem_req_t req;
   } exp_req_t;

   logic                clk;
   logic                rst;
   logic                i_req_i;
   logic [ADDR_W-1:0]   i_addr_i;
   logic                i_rsp_o;
   logic [LINE_W-1:0]   i_rdata_o;
   logic                i_err_o;
   logic                d_req_i;
   logic                d_we_i;
   logic [ADDR_W-1:0]   d_addr_i;
   logic [WORD_W-1:0]   d_wdata_i;
   logic [BE_W-1:0]     d_be_i;
   logic                d_rsp_o;
   logic [WORD_W-1:0]   d_rdata_o;
   logic                d_err_o;
   logic                mem_req_o;
   logic                mem_we_o;
   logic [ADDR_W-1:0]   mem_addr_o;
   logic [LINE_W-1:0]   mem_wdata_o;
   logic [STRB_W-1:0]   mem_wstrb_o;
   logic                mem_rsp_i;
   logic [LINE_W-1:0]   mem_rdata_i;

   int n_checks = 0;
   int n_errors = 0;
   exp_req_t sb[$];

   localparam logic [LINE_W-1:0] LINE_A = 128'h0123456789ABCDEF0123456789ABCDEF;
   localparam logic [LINE_W-1:0] LINE_W4 = {32'h33333333, 32'h22222222, 32'h11111111, 32'h00000000};
   localparam logic [LINE_W-1:0] LINE_J = {32'hA3A3A3A3, 32'hA2A2A2A2, 32'hA1A1A1A1, 32'hA0A0A0A0};
   localparam logic [LINE_W-1:0] LINE_B = 128'hFEEDFACE_CAFEF00D_0BADC0DE_12345678;
   localparam logic [LINE_W-1:0] LINE_C = 128'h55AA55AA_66BB66BB_77CC77CC_88DD88DD;

   srv_mem_arbiter #(.TIMEOUT_CYCLES(4), .CNT_W(8)) dut (
      .clk         (clk),
      .rst         (rst),
      .i_req_i     (i_req_i),
      .i_addr_i    (i_addr_i),
      .i_rsp_o     (i_rsp_o),
      .i_rdata_o   (i_rdata_o),
      .i_err_o     (i_err_o),
      .d_req_i     (d_req_i),
      .d_we_i      (d_we_i),
      .d_addr_i    (d_addr_i),
      .d_wdata_i   (d_wdata_i),
      .d_be_i      (d_be_i),
      .d_rsp_o     (d_rsp_o),
      .d_rdata_o   (d_rdata_o),
      .d_err_o     (d_err_o),
      .mem_req_o   (mem_req_o),
      .mem_we_o    (mem_we_o),
      .mem_addr_o  (mem_addr_o),
      .mem_wdata_o (mem_wdata_o),
      .mem_wstrb_o (mem_wstrb_o),
      .mem_rsp_i   (mem_rsp_i),
      .mem_rdata_i (mem_rdata_i)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1);
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chkw(string tag, logic [191:0] obs, logic [191:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk1(string tag, logic obs, logic exp);
      chkw(tag, 192'(obs), 192'(exp));
   endtask

   task automatic push_i(logic [ADDR_W-1:0] addr);
      exp_req_t e;
      e.is_d      = 1'b0;
      e.req       = '0;
      e.req.addr  = addr;
      sb.push_back(e);
   endtask

   task automatic push_d(logic we, logic [ADDR_W-1:0] addr, logic [WORD_W-1:0] wdata,
                         logic [BE_W-1:0] be);
      exp_req_t e;
      e.is_d      = 1'b1;
      e.req.we    = we;
      e.req.addr  = addr & 32'hFFFF_FFFC;
      e.req.wdata = {wdata, wdata, wdata, wdata};
      e.req.wstrb = 16'h0;
      if (we) begin
         case (addr[1:0])
            2'd0: e.req.wstrb = {12'h000, be};
            2'd1: e.req.wstrb = {8'h00, be, 4'h0};
            2'd2: e.req.wstrb = {4'h0, be, 8'h00};
            default: e.req.wstrb = {be, 12'h000};
         endcase
      end
      sb.push_back(e);
   endtask

   task automatic drive_i(logic [ADDR_W-1:0] addr);
      i_req_i  = 1'b1;
      i_addr_i = addr;
   endtask

   task automatic drive_d(logic we, logic [ADDR_W-1:0] addr, logic [WORD_W-1:0] wdata,
                          logic [BE_W-1:0] be);
      d_req_i   = 1'b1;
      d_we_i    = we;
      d_addr_i  = addr;
      d_wdata_i = wdata;
      d_be_i    = be;
   endtask

   task automatic release_reqs();
      i_req_i   = 1'b0;
      d_req_i   = 1'b0;
      i_addr_i  = 32'h0BAD_0BAD;
      d_addr_i  = 32'h0BAD_0BAD;
      d_wdata_i = 32'h0;
      d_be_i    = 4'h0;
      d_we_i    = 1'b0;
   endtask

   // Wait (bounded) for mem_req_o and check it against the scoreboard head
   task automatic wait_mem_req(string tag);
      exp_req_t e;
      int k;
      k = 0;
      while (!mem_req_o && k < 20) begin
         step();
         k++;
      end
      chk1({tag, "_mem_req"}, mem_req_o, 1'b1);
      chk1({tag, "_sb_nonempty"}, logic'(sb.size() != 0), 1'b1);
      if (sb.size() != 0) begin
         e = sb.pop_front();
         chk1({tag, "_we"}, mem_we_o, e.req.we);
         chkw({tag, "_addr"}, 192'(mem_addr_o), 192'(e.req.addr));
         chkw({tag, "_wstrb"}, 192'(mem_wstrb_o), 192'(e.req.wstrb));
         if (e.is_d) chkw({tag, "_wdata"}, 192'(mem_wdata_o), 192'(e.req.wdata));
      end
   endtask

   task automatic respond(logic [LINE_W-1:0] line);
      mem_rsp_i   = 1'b1;
      mem_rdata_i = line;
      step();
      mem_rsp_i   = 1'b0;
      mem_rdata_i = '0;
   endtask

   task automatic check_rsp(string tag, bit is_d, bit err, logic [LINE_W-1:0] data);
      chk1({tag, "_rsp"}, is_d ? d_rsp_o : i_rsp_o, 1'b1);
      chk1({tag, "_other_rsp"}, is_d ? i_rsp_o : d_rsp_o, 1'b0);
      chk1({tag, "_err"}, is_d ? d_err_o : i_err_o, logic'(err));
      chkw({tag, "_data"}, is_d ? 192'(d_rdata_o) : 192'(i_rdata_o), 192'(data));
   endtask

   task automatic check_quiet(string tag);
      chk1({tag, "_i_rsp"}, i_rsp_o, 1'b0);
      chk1({tag, "_d_rsp"}, d_rsp_o, 1'b0);
      chk1({tag, "_mem_req"}, mem_req_o, 1'b0);
   endtask

   initial begin
      rst = 1'b1;
      mem_rsp_i = 1'b0;
      mem_rdata_i = '0;
      release_reqs();
      step();
      step();
      check_quiet("reset");
      chkw("reset_i_rdata", 192'(i_rdata_o), 192'(0));
      chkw("reset_d_rdata", 192'(d_rdata_o), 192'(0));
      chkw("reset_mem_addr", 192'(mem_addr_o), 192'(0));
      chkw("reset_mem_wdata", 192'(mem_wdata_o), 192'(0));
      chkw("reset_mem_wstrb", 192'(mem_wstrb_o), 192'(0));
      rst = 1'b0;
      step();

      // Single I refill with exact request and response latency
      push_i(32'h40);
      drive_i(32'h40);
      step();
      release_reqs();
      chk1("i1_lat_n1", mem_req_o, 1'b0);
      step();
      wait_mem_req("i1");
      step();
      chk1("i1_req_pulse", mem_req_o, 1'b0);
      step();
      step();
      respond(LINE_A);
      check_rsp("i1", 1'b0, 1'b0, LINE_A);
      step();
      chk1("i1_rsp_pulse", i_rsp_o, 1'b0);
      chkw("i1_rdata_hold", 192'(i_rdata_o), 192'(LINE_A));

      // D read word select
      push_d(1'b0, 32'h22, 32'h0, 4'h0);
      drive_d(1'b0, 32'h22, 32'h0, 4'h0);
      step();
      release_reqs();
      wait_mem_req("drd");
      respond(LINE_W4);
      check_rsp("drd", 1'b1, 1'b0, 128'(32'h22222222));

      // D write; a second D pulse while busy must be dropped
      push_d(1'b1, 32'h12, 32'hDEADBEEF, 4'b0011);
      drive_d(1'b1, 32'h12, 32'hDEADBEEF, 4'b0011);
      step();
      release_reqs();
      wait_mem_req("dwr");
      step();
      drive_d(1'b0, 32'h7, 32'h0, 4'h0);
      step();
      release_reqs();
      respond(LINE_J);
      check_rsp("dwr", 1'b1, 1'b0, 128'(32'h22222222));
      for (int k = 0; k < 3; k++) begin
         step();
         check_quiet("dwr_drop");
      end

      // Tie with last grant D: I first, D at M+2
      push_i(32'h80);
      push_d(1'b0, 32'h31, 32'h0, 4'h0);
      drive_i(32'h80);
      drive_d(1'b0, 32'h31, 32'h0, 4'h0);
      step();
      release_reqs();
      wait_mem_req("tie1_i");
      respond(LINE_B);
      check_rsp("tie1_i", 1'b0, 1'b0, LINE_B);
      chk1("tie1_gap", mem_req_o, 1'b0);
      step();
      wait_mem_req("tie1_d");
      respond(LINE_W4);
      check_rsp("tie1_d", 1'b1, 1'b0, 128'(32'h11111111));

      // Lone I makes I the last grant, so the next tie goes to D
      push_i(32'h100);
      drive_i(32'h100);
      step();
      release_reqs();
      wait_mem_req("i2");
      respond(LINE_C);
      check_rsp("i2", 1'b0, 1'b0, LINE_C);
      step();
      push_d(1'b0, 32'h20, 32'h0, 4'h0);
      push_i(32'h140);
      drive_i(32'h140);
      drive_d(1'b0, 32'h20, 32'h0, 4'h0);
      step();
      release_reqs();
      wait_mem_req("tie2_d");
      respond(LINE_W4);
      check_rsp("tie2_d", 1'b1, 1'b0, 128'(32'h00000000));
      step();
      wait_mem_req("tie2_i");
      respond(LINE_A);
      check_rsp("tie2_i", 1'b0, 1'b0, LINE_A);

      // Response arriving in the timeout cycle wins
      push_i(32'h180);
      drive_i(32'h180);
      step();
      release_reqs();
      wait_mem_req("tow");
      for (int k = 1; k <= 4; k++) step();
      chk1("tow_no_early", i_rsp_o, 1'b0);
      respond(LINE_B);
      check_rsp("tow", 1'b0, 1'b0, LINE_B);

      // Timeout: error completion 5 cycles after mem_req_o
      push_i(32'h1C0);
      drive_i(32'h1C0);
      step();
      release_reqs();
      wait_mem_req("to");
      for (int k = 1; k <= 4; k++) begin
         step();
         chk1("to_wait", i_rsp_o, 1'b0);
      end
      step();
      check_rsp("to", 1'b0, 1'b1, LINE_B);
      step();
      step();
      respond(LINE_C);
      check_quiet("late_rsp");
      chkw("late_rsp_i_rdata", 192'(i_rdata_o), 192'(LINE_B));
      push_d(1'b0, 32'h33, 32'h0, 4'h0);
      drive_d(1'b0, 32'h33, 32'h0, 4'h0);
      step();
      release_reqs();
      wait_mem_req("after_to");
      respond(LINE_W4);
      check_rsp("after_to", 1'b1, 1'b0, 128'(32'h33333333));

      // Asynchronous reset while BUSY_D
      push_d(1'b0, 32'h2C, 32'h0, 4'h0);
      drive_d(1'b0, 32'h2C, 32'h0, 4'h0);
      step();
      release_reqs();
      wait_mem_req("rst_d");
      step();
      #2 rst = 1'b1;
      #1;
      check_quiet("async_rst");
      chkw("async_rst_addr", 192'(mem_addr_o), 192'(0));
      chkw("async_rst_d_rdata", 192'(d_rdata_o), 192'(0));
      chkw("async_rst_i_rdata", 192'(i_rdata_o), 192'(0));
      step();
      rst = 1'b0;
      step();
      respond(LINE_W4);
      check_quiet("post_rst_rsp");
      push_i(32'h200);
      drive_i(32'h200);
      step();
      release_reqs();
      chk1("post_rst_lat_n1", mem_req_o, 1'b0);
      step();
      wait_mem_req("post_rst_i");
      respond(LINE_C);
      check_rsp("post_rst_i", 1'b0, 1'b0, LINE_C);

      chkw("sb_drained", 192'(sb.size()), 192'(0));
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
